// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier and restoring divider,
// one step per cycle, WIDTH steps per operation, then a sign-fix cycle.
module mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  logic [1:0]         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;   // product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor
  logic [WIDTH-1:0]   mpl_q;   // multiplier, consumed MSB first
  logic               div_q;
  logic               neg_q;   // negate product/quotient in the fix cycle
  logic               rneg_q;  // negate remainder in the fix cycle

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] mul_acc, div_acc, fix_res;
  logic [WIDTH:0]     rem_sh, diff;
  logic               last_step;

  // Magnitudes of the most-negative value stay exact when read as unsigned.
  always_comb begin
    is_signed = (op_i == 3'd0) || (op_i == 3'd2);
    a_neg     = is_signed & a_i[WIDTH-1];
    b_neg     = is_signed & b_i[WIDTH-1];
    a_abs     = a_neg ? -a_i : a_i;
    b_abs     = b_neg ? -b_i : b_i;
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    mul_acc = {acc_q[2*WIDTH-2:0], 1'b0} + (mpl_q[WIDTH-1] ? {{WIDTH{1'b0}}, opnd_q} : '0);
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    if (!diff[WIDTH]) begin
      div_acc = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    fix_res = acc_q;
    if (div_q) begin
      fix_res[WIDTH-1:0]       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_res[2*WIDTH-1:WIDTH] = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      fix_res = -acc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      mpl_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            case (op_i)
              3'd0, 3'd1: begin
                acc_q   <= '0;
                opnd_q  <= a_abs;
                mpl_q   <= b_abs;
                div_q   <= 1'b0;
                neg_q   <= a_neg ^ b_neg;
                rneg_q  <= 1'b0;
                cnt_q   <= '0;
                busy_o  <= 1'b1;
                state_q <= StMul;
              end
              3'd2, 3'd3: begin
                acc_q   <= {{WIDTH{1'b0}}, a_abs};
                opnd_q  <= b_abs;
                mpl_q   <= '0;
                div_q   <= 1'b1;
                // Divide by zero leaves quotient all ones whatever the dividend sign.
                neg_q   <= (a_neg ^ b_neg) & (b_i != '0);
                rneg_q  <= a_neg;
                cnt_q   <= '0;
                busy_o  <= 1'b1;
                state_q <= StDiv;
              end
              3'd4:    hi_o <= a_i;
              3'd5:    lo_o <= a_i;
              default: ;
            endcase
          end
        end
        StMul: begin
          acc_q <= mul_acc;
          mpl_q <= {mpl_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (last_step) state_q <= StFix;
        end
        StDiv: begin
          acc_q <= div_acc;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) state_q <= StFix;
        end
        StFix: begin
          hi_o    <= fix_res[2*WIDTH-1:WIDTH];
          lo_o    <= fix_res[WIDTH-1:0];
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected {hi,lo} queued at issue, compared on the done pulse.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  mdu #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy, q, r;
    case (o)
      3'd0: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ix = x;
        iy = y;
        q  = ix / iy;
        r  = ix % iy;
        return {r, q};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called on a falling edge; poke>0 re-requests a DIVU on that falling edge of the run.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke);
    logic [63:0] old, want;
    int cyc, bcnt;
    old = {hi, lo};
    exp_q.push_back(model(o, x, y));
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    cyc   = 0;
    bcnt  = 0;
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) break;
      if (busy) bcnt++;
      a = $urandom;
      b = $urandom;
      if (cyc == 17) check({tag, "_hold"}, {hi, lo}, old);
      if (cyc == poke) begin
        start = 1'b1;
        op    = 3'd3;
      end
    end
    want = exp_q.pop_front();
    if (!done) begin
      check({tag, "_timeout"}, {63'd0, done}, 64'd1);
    end else begin
      // Done is seen on the 34th falling edge, i.e. just after the edge 33 cycles past start.
      check({tag, "_latency"}, 64'(cyc), 64'd34);
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
      check({tag, "_result"}, {hi, lo}, want);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7, 0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, 0);
    run_op("div_zero_neg", 3'd2, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("mult_poke", 3'd0, 32'h1234_5678, 32'hFEDC_BA98, 10);
    run_op("multu_poke_fix", 3'd1, 32'hDEAD_BEEF, 32'h0000_1001, 33);
    run_op("divu_b2b", 3'd3, 32'hFFFF_FFFF, 32'h0000_0003, 0);

    start = 1'b1; op = 3'd5; a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'h1234);
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; op = 3'd4; a = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hilo", {hi, lo}, 64'hCAFE_0001_0000_1234);
    check("mthi_done", {63'd0, done}, 64'd0);
    start = 1'b1; op = 3'd7; a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check("reserved_hilo", {hi, lo}, 64'hCAFE_0001_0000_1234);
    check("reserved_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op("random", 3'($urandom_range(0, 3)), $urandom, $urandom, 0);
    end

    // Reset in the middle of a divide.
    start = 1'b1; op = 3'd2; a = 32'h7654_3210; b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    run_op("after_rst", 3'd1, 32'd3, 32'd5, 0);
    check("after_rst_const", {hi, lo}, 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
